// File: rtl/seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
//
// Inverse of the timer's seven-segment encoder. A one-cycle Start snapshots the
// four driven digit patterns and the FSM then decodes one digit per clock. It
// recovers the two 0-99 pair values, recognises the "End" display and reports
// the first illegal digit.
//
// Ports
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   Start        one-cycle request; snapshots the four Hex inputs when idle
//   HexMSBH      tens digit of MSB pair   {g,f,e,d,c,b,a}
//   HexMSBL      units digit of MSB pair
//   HexLSBH      tens digit of LSB pair
//   HexLSBL      units digit of LSB pair
//   Busy         high from capture until results are published
//   Done         one-cycle pulse when the result outputs update
//   MSBBinary    decoded MSB pair (0-99), 0 unless Valid
//   LSBBinary    decoded LSB pair (0-99), 0 unless Valid
//   Valid        all digits legal (leading blank allowed when configured)
//   EndDetected  snapshot was the "End" display
//   ErrIndex     index of first illegal digit (0=MSBH .. 3=LSBL), 0 when Valid
// -----------------------------------------------------------------------------
module seven_seg_decoder #(
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_IS_ZERO = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       Start,
    input  logic [6:0] HexMSBH,
    input  logic [6:0] HexMSBL,
    input  logic [6:0] HexLSBH,
    input  logic [6:0] HexLSBL,
    output logic       Busy,
    output logic       Done,
    output logic [7:0] MSBBinary,
    output logic [7:0] LSBBinary,
    output logic       Valid,
    output logic       EndDetected,
    output logic [1:0] ErrIndex
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       numeric;  // pattern is one of the digits 0-9
        logic       blank;    // all segments off
        logic [3:0] value;    // digit value when numeric, else 0
    } digit_t;

    // Patterns below are in active-low form (bit clear = segment lit).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_N     = 7'h2B;
    localparam logic [6:0] SEG_D     = 7'h21;

    // Bring every input pattern into the active-low form used by the tables.
    function automatic logic [6:0] normalise(input logic [6:0] raw);
        return ACTIVE_LOW ? raw : ~raw;
    endfunction

    function automatic digit_t decode_digit(input logic [6:0] seg);
        digit_t d;
        d = '{numeric: 1'b1, blank: 1'b0, value: 4'd0};
        case (seg)
            7'h40: d.value = 4'd0;
            7'h79: d.value = 4'd1;
            7'h24: d.value = 4'd2;
            7'h30: d.value = 4'd3;
            7'h19: d.value = 4'd4;
            7'h12: d.value = 4'd5;
            7'h02: d.value = 4'd6;
            7'h78: d.value = 4'd7;
            7'h00: d.value = 4'd8;
            7'h10: d.value = 4'd9;
            SEG_BLANK: begin
                d.numeric = 1'b0;
                d.blank   = 1'b1;
            end
            default: d.numeric = 1'b0;
        endcase
        return d;
    endfunction

    state_t     state_q, next_state;
    logic [1:0] idx_q;
    logic [6:0] snapshot_q [4];  // 0=MSBH, 1=MSBL, 2=LSBH, 3=LSBL
    logic [7:0] msb_acc_q, lsb_acc_q;
    logic       err_found_q;
    logic [1:0] err_idx_q;

    logic       accept;
    digit_t     cur_digit;
    logic       digit_ok;
    logic [7:0] digit_val;
    logic [7:0] digit_tens;
    logic       end_match;

    // A Start coinciding with the Done pulse is dropped, so the next request
    // cannot overlap the cycle in which results are being consumed.
    assign accept = (state_q == IDLE) && Start && !Done;

    // Even indices are tens digits and may be a leading blank; odd indices
    // are units digits and must be numeric.
    assign cur_digit  = decode_digit(snapshot_q[idx_q]);
    assign digit_ok   = cur_digit.numeric ||
                        (!idx_q[0] && cur_digit.blank && BLANK_IS_ZERO);
    assign digit_val  = {4'd0, cur_digit.value};
    assign digit_tens = (digit_val << 3) + (digit_val << 1);

    assign end_match = (snapshot_q[0] == SEG_BLANK) && (snapshot_q[1] == SEG_E) &&
                       (snapshot_q[2] == SEG_N)     && (snapshot_q[3] == SEG_D);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        next_state = state_q;
        case (state_q)
            IDLE:    if (accept) next_state = SCAN;
            SCAN:    if (idx_q == 2'd3) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 2'd0;
            msb_acc_q   <= 8'd0;
            lsb_acc_q   <= 8'd0;
            err_found_q <= 1'b0;
            err_idx_q   <= 2'd0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            MSBBinary   <= 8'd0;
            LSBBinary   <= 8'd0;
            Valid       <= 1'b0;
            EndDetected <= 1'b0;
            ErrIndex    <= 2'd0;
            // NOTE: the snapshot is a small register file with a defined reset
            // value (all blank), so it is cleared here like any other register.
            for (int i = 0; i < 4; i++) snapshot_q[i] <= SEG_BLANK;
        end else begin
            state_q <= next_state;
            Done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        snapshot_q[0] <= normalise(HexMSBH);
                        snapshot_q[1] <= normalise(HexMSBL);
                        snapshot_q[2] <= normalise(HexLSBH);
                        snapshot_q[3] <= normalise(HexLSBL);
                        idx_q         <= 2'd0;
                        msb_acc_q     <= 8'd0;
                        lsb_acc_q     <= 8'd0;
                        err_found_q   <= 1'b0;
                        err_idx_q     <= 2'd0;
                        Busy          <= 1'b1;
                    end
                end
                SCAN: begin
                    idx_q <= idx_q + 2'd1;
                    case (idx_q)
                        2'd0: msb_acc_q <= digit_tens;
                        2'd1: msb_acc_q <= msb_acc_q + digit_val;
                        2'd2: lsb_acc_q <= digit_tens;
                        2'd3: lsb_acc_q <= lsb_acc_q + digit_val;
                        default: ;
                    endcase
                    if (!digit_ok && !err_found_q) begin
                        err_found_q <= 1'b1;
                        err_idx_q   <= idx_q;
                    end
                end
                DONE: begin
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    if (end_match) begin
                        // "End" is a recognised display, not an error.
                        EndDetected <= 1'b1;
                        Valid       <= 1'b0;
                        ErrIndex    <= 2'd0;
                        MSBBinary   <= 8'd0;
                        LSBBinary   <= 8'd0;
                    end else if (err_found_q) begin
                        EndDetected <= 1'b0;
                        Valid       <= 1'b0;
                        ErrIndex    <= err_idx_q;
                        MSBBinary   <= 8'd0;
                        LSBBinary   <= 8'd0;
                    end else begin
                        EndDetected <= 1'b0;
                        Valid       <= 1'b1;
                        ErrIndex    <= 2'd0;
                        MSBBinary   <= msb_acc_q;
                        LSBBinary   <= lsb_acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_decoder
//
// Three decoder instances share clock, reset and Hex inputs: the default build,
// one with BLANK_IS_ZERO=0 and one with ACTIVE_LOW=0. Each has its own Start so
// a scenario can target one build. Expected results are pushed into a
// per-instance queue when an accepted Start is driven and popped on Done.
// -----------------------------------------------------------------------------
module tb_seven_seg_decoder;

    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       valid;
        logic       end_det;
        logic [1:0] err;
    } result_t;

    localparam logic [6:0] SEG_CODE [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start_m = 1'b0, start_nb = 1'b0, start_ah = 1'b0;
    logic [6:0] hex_mh = 7'h7F, hex_ml = 7'h7F, hex_lh = 7'h7F, hex_ll = 7'h7F;

    logic       busy_m, done_m, valid_m, end_m;
    logic [7:0] msb_m, lsb_m;
    logic [1:0] err_m;
    logic       busy_nb, done_nb, valid_nb, end_nb;
    logic [7:0] msb_nb, lsb_nb;
    logic [1:0] err_nb;
    logic       busy_ah, done_ah, valid_ah, end_ah;
    logic [7:0] msb_ah, lsb_ah;
    logic [1:0] err_ah;

    result_t q_m[$], q_nb[$], q_ah[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      done_cnt_m = 0;

    always #5 clock = ~clock;

    seven_seg_decoder #(.ACTIVE_LOW(1'b1), .BLANK_IS_ZERO(1'b1)) dut (
        .clock(clock), .reset(reset), .Start(start_m),
        .HexMSBH(hex_mh), .HexMSBL(hex_ml), .HexLSBH(hex_lh), .HexLSBL(hex_ll),
        .Busy(busy_m), .Done(done_m), .MSBBinary(msb_m), .LSBBinary(lsb_m),
        .Valid(valid_m), .EndDetected(end_m), .ErrIndex(err_m)
    );

    seven_seg_decoder #(.ACTIVE_LOW(1'b1), .BLANK_IS_ZERO(1'b0)) dut_nb (
        .clock(clock), .reset(reset), .Start(start_nb),
        .HexMSBH(hex_mh), .HexMSBL(hex_ml), .HexLSBH(hex_lh), .HexLSBL(hex_ll),
        .Busy(busy_nb), .Done(done_nb), .MSBBinary(msb_nb), .LSBBinary(lsb_nb),
        .Valid(valid_nb), .EndDetected(end_nb), .ErrIndex(err_nb)
    );

    seven_seg_decoder #(.ACTIVE_LOW(1'b0), .BLANK_IS_ZERO(1'b1)) dut_ah (
        .clock(clock), .reset(reset), .Start(start_ah),
        .HexMSBH(hex_mh), .HexMSBL(hex_ml), .HexLSBH(hex_lh), .HexLSBL(hex_ll),
        .Busy(busy_ah), .Done(done_ah), .MSBBinary(msb_ah), .LSBBinary(lsb_ah),
        .Valid(valid_ah), .EndDetected(end_ah), .ErrIndex(err_ah)
    );

    // Reference decode of four active-low patterns.
    function automatic result_t model(input logic [6:0] d0, input logic [6:0] d1,
                                      input logic [6:0] d2, input logic [6:0] d3,
                                      input bit blank_zero);
        logic [6:0] d [4];
        int         v [4];
        result_t    r;
        r = '0;
        d = '{d0, d1, d2, d3};
        if (d0 == 7'h7F && d1 == 7'h06 && d2 == 7'h2B && d3 == 7'h21) begin
            r.end_det = 1'b1;
            return r;
        end
        for (int i = 0; i < 4; i++) begin
            v[i] = -1;
            for (int k = 0; k < 10; k++) if (d[i] == SEG_CODE[k]) v[i] = k;
            if (v[i] < 0 && (i % 2) == 0 && blank_zero && d[i] == 7'h7F) v[i] = 0;
            if (v[i] < 0) begin
                r.err = 2'(i);
                return r;
            end
        end
        r.valid = 1'b1;
        r.msb   = 8'(v[0] * 10 + v[1]);
        r.lsb   = 8'(v[2] * 10 + v[3]);
        return r;
    endfunction

    // Scoreboard: every Done pops one expectation from its instance's queue.
    always @(negedge clock) begin
        result_t act, exp;
        if (done_m) begin
            done_cnt_m++;
            n_cmp++;
            act = {msb_m, lsb_m, valid_m, end_m, err_m};
            if (q_m.size() == 0) begin
                n_bad++;
                $display("FAIL main_unexpected_done got=%h", act);
            end else begin
                exp = q_m.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL main_result got=%h want=%h (msb,lsb,valid,end,err)", act, exp);
                end
            end
        end
        if (done_nb) begin
            n_cmp++;
            act = {msb_nb, lsb_nb, valid_nb, end_nb, err_nb};
            if (q_nb.size() == 0) begin
                n_bad++;
                $display("FAIL noblank_unexpected_done got=%h", act);
            end else begin
                exp = q_nb.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL noblank_result got=%h want=%h", act, exp);
                end
            end
        end
        if (done_ah) begin
            n_cmp++;
            act = {msb_ah, lsb_ah, valid_ah, end_ah, err_ah};
            if (q_ah.size() == 0) begin
                n_bad++;
                $display("FAIL acthigh_unexpected_done got=%h", act);
            end else begin
                exp = q_ah.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL acthigh_result got=%h want=%h", act, exp);
                end
            end
        end
    end

    task automatic drive_hex(input logic [6:0] a, input logic [6:0] b,
                             input logic [6:0] c, input logic [6:0] d);
        hex_mh = a; hex_ml = b; hex_lh = c; hex_ll = d;
    endtask

    // Bounded wait for all outstanding requests to produce their Done.
    task automatic wait_drain(input string name);
        repeat (10) @(negedge clock);
        n_cmp++;
        if (q_m.size() + q_nb.size() + q_ah.size() != 0) begin
            n_bad++;
            $display("FAIL %s_pending got=%0d want=0", name,
                     q_m.size() + q_nb.size() + q_ah.size());
        end
    endtask

    task automatic test_reset();
        result_t act;
        // Start held together with reset must not launch a scan.
        reset = 1'b1; start_m = 1'b1;
        drive_hex(SEG_CODE[1], SEG_CODE[1], SEG_CODE[1], SEG_CODE[1]);
        repeat (2) @(negedge clock);
        act = {msb_m, lsb_m, valid_m, end_m, err_m};
        n_cmp++;
        if (act !== '0) begin n_bad++; $display("FAIL reset_outputs got=%h want=0", act); end
        n_cmp++;
        if ({busy_m, done_m} !== 2'b00) begin
            n_bad++; $display("FAIL reset_busy_done got=%b want=00", {busy_m, done_m});
        end
        reset = 1'b0; start_m = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (busy_m !== 1'b0) begin n_bad++; $display("FAIL reset_start_ignored got=%b want=0", busy_m); end
    endtask

    task automatic test_basic();
        @(negedge clock);
        drive_hex(SEG_CODE[1], SEG_CODE[2], SEG_CODE[0], SEG_CODE[7]);
        start_m = 1'b1;
        q_m.push_back(model(SEG_CODE[1], SEG_CODE[2], SEG_CODE[0], SEG_CODE[7], 1'b1));
        @(negedge clock);  // edge N has sampled Start
        start_m = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            n_cmp++;
            if (done_m !== (k == 5)) begin
                n_bad++; $display("FAIL basic_done_k%0d got=%b want=%b", k, done_m, k == 5);
            end
            n_cmp++;
            if (busy_m !== (k < 5)) begin
                n_bad++; $display("FAIL basic_busy_k%0d got=%b want=%b", k, busy_m, k < 5);
            end
        end
        wait_drain("basic");
    endtask

    task automatic test_blank();
        @(negedge clock);
        drive_hex(7'h7F, SEG_CODE[5], SEG_CODE[9], SEG_CODE[9]);
        start_m = 1'b1; start_nb = 1'b1;
        q_m.push_back(model(7'h7F, SEG_CODE[5], SEG_CODE[9], SEG_CODE[9], 1'b1));
        q_nb.push_back(model(7'h7F, SEG_CODE[5], SEG_CODE[9], SEG_CODE[9], 1'b0));
        @(negedge clock);
        start_m = 1'b0; start_nb = 1'b0;
        wait_drain("blank");
    endtask

    task automatic test_end();
        @(negedge clock);
        drive_hex(7'h7F, 7'h06, 7'h2B, 7'h21);
        start_m = 1'b1;
        q_m.push_back(model(7'h7F, 7'h06, 7'h2B, 7'h21, 1'b1));
        @(negedge clock);
        start_m = 1'b0;
        wait_drain("end");
    endtask

    task automatic test_illegal();
        @(negedge clock);
        drive_hex(SEG_CODE[3], SEG_CODE[0], 7'h55, 7'h01);
        start_m = 1'b1;
        q_m.push_back(model(SEG_CODE[3], SEG_CODE[0], 7'h55, 7'h01, 1'b1));
        @(negedge clock);
        start_m = 1'b0;
        wait_drain("illegal");
    endtask

    task automatic test_mid_change();
        int cnt0;
        cnt0 = done_cnt_m;
        @(negedge clock);
        drive_hex(SEG_CODE[4], SEG_CODE[5], SEG_CODE[6], SEG_CODE[7]);
        start_m = 1'b1;
        q_m.push_back(model(SEG_CODE[4], SEG_CODE[5], SEG_CODE[6], SEG_CODE[7], 1'b1));
        @(negedge clock);  // after edge N
        start_m = 1'b0;
        @(negedge clock);  // after edge N+1: new inputs and Start sampled at N+2
        drive_hex(SEG_CODE[9], SEG_CODE[9], SEG_CODE[9], SEG_CODE[9]);
        start_m = 1'b1;
        @(negedge clock);
        start_m = 1'b0;
        wait_drain("midchange");
        n_cmp++;
        if (done_cnt_m - cnt0 != 1) begin
            n_bad++; $display("FAIL midchange_done_count got=%0d want=1", done_cnt_m - cnt0);
        end
    endtask

    task automatic test_reset_mid();
        int      cnt0;
        result_t act;
        cnt0 = done_cnt_m;
        @(negedge clock);
        drive_hex(SEG_CODE[8], SEG_CODE[8], SEG_CODE[8], SEG_CODE[8]);
        start_m = 1'b1;
        @(negedge clock);  // after edge N
        start_m = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;      // sampled at edge N+3
        @(negedge clock);
        reset = 1'b0;
        act = {msb_m, lsb_m, valid_m, end_m, err_m};
        n_cmp++;
        if (act !== '0) begin n_bad++; $display("FAIL resetmid_outputs got=%h want=0", act); end
        n_cmp++;
        if ({busy_m, done_m} !== 2'b00) begin
            n_bad++; $display("FAIL resetmid_busy_done got=%b want=00", {busy_m, done_m});
        end
        repeat (8) @(negedge clock);
        n_cmp++;
        if (done_cnt_m != cnt0) begin
            n_bad++; $display("FAIL resetmid_no_done got=%0d want=0", done_cnt_m - cnt0);
        end
        drive_hex(SEG_CODE[9], SEG_CODE[8], SEG_CODE[7], SEG_CODE[6]);
        start_m = 1'b1;
        q_m.push_back(model(SEG_CODE[9], SEG_CODE[8], SEG_CODE[7], SEG_CODE[6], 1'b1));
        @(negedge clock);
        start_m = 1'b0;
        wait_drain("resetmid_fresh");
    endtask

    task automatic test_active_high();
        @(negedge clock);
        drive_hex(~SEG_CODE[4], ~SEG_CODE[2], ~SEG_CODE[1], ~SEG_CODE[8]);
        start_ah = 1'b1;
        q_ah.push_back(model(SEG_CODE[4], SEG_CODE[2], SEG_CODE[1], SEG_CODE[8], 1'b1));
        @(negedge clock);
        start_ah = 1'b0;
        wait_drain("activehigh");
    endtask

    task automatic test_back_to_back();
        bit seen;
        @(negedge clock);
        drive_hex(SEG_CODE[2], SEG_CODE[3], SEG_CODE[4], SEG_CODE[5]);
        start_m = 1'b1;
        q_m.push_back(model(SEG_CODE[2], SEG_CODE[3], SEG_CODE[4], SEG_CODE[5], 1'b1));
        @(negedge clock);
        start_m = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clock);
            seen = done_m;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++; $display("FAIL b2b_done_timeout got=0 want=1");
        end else begin
            // Start during the Done-high cycle must be dropped.
            drive_hex(SEG_CODE[6], SEG_CODE[6], SEG_CODE[6], SEG_CODE[6]);
            start_m = 1'b1;
            @(negedge clock);
            n_cmp++;
            if (busy_m !== 1'b0) begin
                n_bad++; $display("FAIL b2b_start_in_done got=%b want=0", busy_m);
            end
            // The very next cycle is accepted.
            drive_hex(SEG_CODE[7], SEG_CODE[7], SEG_CODE[1], SEG_CODE[1]);
            q_m.push_back(model(SEG_CODE[7], SEG_CODE[7], SEG_CODE[1], SEG_CODE[1], 1'b1));
            @(negedge clock);
            start_m = 1'b0;
            n_cmp++;
            if (busy_m !== 1'b1) begin
                n_bad++; $display("FAIL b2b_next_accepted got=%b want=1", busy_m);
            end
        end
        start_m = 1'b0;
        wait_drain("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_end();
        test_illegal();
        test_mid_change();
        test_reset_mid();
        test_active_high();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
